// File: rtl/seg_text_scroller.sv
// Scrolls character-ROM patterns through an NDIG-digit buffer and multiplexes it onto a 7-seg bus.
// Optional build macro SCROLL_ONESHOT_EN: stop after one full 16-character pass instead of looping.
module seg_text_scroller #(
    parameter int SCROLL_DIV = 12500000,
    parameter int SCAN_DIV   = 50000,
    parameter int NDIG       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            hold,
    input  logic            clr,
    output logic [3:0]      rom_adr,
    input  logic [7:0]      rom_dat,
    output logic [7:0]      seg,
    output logic [NDIG-1:0] an,
    output logic            busy,
    output logic            wrap
);
    localparam int PW = $clog2(SCROLL_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NDIG);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCROLL_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NDIG - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [3:0]      adr_q, adr_d;
    logic [7:0]      buf_q [NDIG];
    logic [7:0]      buf_d [NDIG];
    logic [SW-1:0]   scan_q, scan_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      seg_q;
    logic [NDIG-1:0] an_q;
    logic            wrap_q;
    logic            step, wrap_step, arm, stop_on_wrap;

    // clr suppresses the step entirely, so nothing shifts and no wrap is reported
    assign step      = (state_q == S_RUN) && (presc_q == PRESC_MAX) && !clr;
    assign wrap_step = step && (adr_q == 4'hF);

`ifdef SCROLL_ONESHOT_EN
    logic done_q, done_d;

    // After a completed pass, run must be seen low before the next start
    always_comb begin
        done_d = done_q;
        if (!run)
            done_d = 1'b0;
        else if (wrap_step)
            done_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b0;
        else        done_q <= done_d;
    end

    assign arm          = !done_q;
    assign stop_on_wrap = wrap_step;
`else
    assign arm          = 1'b1;
    assign stop_on_wrap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (run && arm)              state_d = S_RUN;
            S_RUN:   if (!run || stop_on_wrap)    state_d = S_IDLE;
                     else if (hold)               state_d = S_PAUSE;
            S_PAUSE: if (!run)                    state_d = S_IDLE;
                     else if (!hold)              state_d = S_RUN;
            default:                              state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    always_comb begin
        presc_d = presc_q;
        adr_d   = adr_q;
        for (int k = 0; k < NDIG; k++) buf_d[k] = buf_q[k];
        if (clr) begin
            presc_d = '0;
            adr_d   = 4'h0;
            for (int k = 0; k < NDIG; k++) buf_d[k] = 8'hFF;
        end else begin
            if (state_d == S_IDLE)
                presc_d = '0;
            else if (state_q == S_RUN)
                presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
            if (step) begin
                adr_d    = adr_q + 4'h1;
                buf_d[0] = rom_dat;
                for (int k = 1; k < NDIG; k++) buf_d[k] = buf_q[k-1];
            end
        end
    end

    always_comb begin
        scan_d = (scan_q == SCAN_MAX) ? '0 : scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SCAN_MAX)
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            adr_q   <= 4'h0;
            for (int k = 0; k < NDIG; k++) buf_q[k] <= 8'hFF;
            scan_q  <= '0;
            idx_q   <= '0;
            seg_q   <= 8'hFF;
            an_q    <= '1;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            adr_q   <= adr_d;
            for (int k = 0; k < NDIG; k++) buf_q[k] <= buf_d[k];
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            seg_q   <= buf_q[idx_q];
            an_q    <= ~(NDIG'(1) << idx_q);
            wrap_q  <= wrap_step;
        end
    end

    assign rom_adr = adr_q;
    assign seg     = seg_q;
    assign an      = an_q;
    assign wrap    = wrap_q;
endmodule

// File: tb/tb_seg_text_scroller.sv
// Directed bench for seg_text_scroller with SCROLL_DIV=4, SCAN_DIV=2, NDIG=4 and ROM = 8'h10 + adr.
module tb_seg_text_scroller;
    localparam int NDIG = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            run = 1'b0;
    logic            hold = 1'b0;
    logic            clr = 1'b0;
    logic [3:0]      rom_adr;
    logic [7:0]      rom_dat;
    logic [7:0]      seg;
    logic [NDIG-1:0] an;
    logic            busy;
    logic            wrap;

    int errors = 0;
    int checks = 0;

    assign rom_dat = 8'h10 + {4'h0, rom_adr};
    always #5 clk = ~clk;

    seg_text_scroller #(.SCROLL_DIV(4), .SCAN_DIV(2), .NDIG(NDIG)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .hold(hold), .clr(clr),
        .rom_adr(rom_adr), .rom_dat(rom_dat), .seg(seg), .an(an),
        .busy(busy), .wrap(wrap)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: wait bound expired, an=%0h rom_adr=%0h", tag, an, rom_adr);
    endtask

    // Wait (bounded) for digit k to be enabled, then compare the segment bus.
    task automatic check_digit(input int k, input logic [7:0] exp, input string tag);
        logic [NDIG-1:0] want;
        want = ~(NDIG'(1) << k);
        for (int i = 0; i < 16 && an !== want; i++) tick(1);
        if (an !== want) timeout(tag);
        else chk(tag, seg, exp);
    endtask

    initial begin
        logic [NDIG-1:0] an_prev;
        int              changes;
        int              wraps;

        // Reset state
        tick(1);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_an", an, 4'hF);
        chk("rst_adr", rom_adr, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        rst_n = 1'b1;
        tick(1);
        chk("first_an", an, 4'hE);

        // Run from reset: steps on the 5th, 9th, 13th, 17th edge
        run = 1'b1;
        tick(4);
        chk("busy_run", busy, 1'b1);
        chk("pre_step1", rom_adr, 4'h0);
        tick(1);
        chk("step1", rom_adr, 4'h1);
        for (int s = 2; s <= 4; s++) begin
            tick(3);
            chk("pre_step", rom_adr, 4'(s - 1));
            tick(1);
            chk("step", rom_adr, 4'(s));
        end
        run = 1'b0;
        tick(1);
        chk("idle_busy", busy, 1'b0);

        // Scan order and slot length on the frozen buffer {10,11,12,13}
        for (int i = 0; i < 16 && an !== 4'h7; i++) tick(1);
        if (an !== 4'h7) timeout("scan_sync");
        for (int i = 0; i < 4 && an === 4'h7; i++) tick(1);
        chk("scan_an0", an, 4'hE);
        chk("scan_seg0", seg, 8'h13);
        tick(1);
        chk("scan_an0_hold", an, 4'hE);
        tick(1);
        chk("scan_an1", an, 4'hD);
        chk("scan_seg1", seg, 8'h12);
        check_digit(2, 8'h11, "digit2");
        check_digit(3, 8'h10, "digit3");
        chk("idle_adr", rom_adr, 4'h4);

        // Restart: prescaler starts over, step SCROLL_DIV cycles after entering RUN
        run = 1'b1;
        tick(4);
        chk("restart_pre", rom_adr, 4'h4);
        tick(1);
        chk("restart_step", rom_adr, 4'h5);

        // Hold for 10 cycles with the prescaler at 2 -> 3
        tick(2);
        hold = 1'b1;
        an_prev = an;
        changes = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (an !== an_prev) changes++;
            an_prev = an;
        end
        chk("hold_adr", rom_adr, 4'h5);
        chk("hold_busy", busy, 1'b1);
        chk("hold_an_rot", changes, 5);
        chk("hold_onehot", $countones(~an), 1);
        check_digit(0, 8'h14, "hold_buf0");
        hold = 1'b0;
        tick(1);
        chk("resume_pre", rom_adr, 4'h5);
        tick(1);
        chk("resume_step", rom_adr, 4'h6);

        // clr on the step cycle wins; next step loads 8'h10
        tick(3);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_adr", rom_adr, 4'h0);
        chk("clr_busy", busy, 1'b1);
        tick(3);
        chk("clr_pre", rom_adr, 4'h0);
        tick(1);
        chk("clr_step", rom_adr, 4'h1);
        run = 1'b0;
        tick(1);
        check_digit(0, 8'h10, "clr_buf0");
        check_digit(1, 8'hFF, "clr_buf1");
        check_digit(3, 8'hFF, "clr_buf3");

        // Wrap 15 -> 0
        run = 1'b1;
        wraps = 0;
        for (int i = 0; i < 300 && rom_adr !== 4'hF; i++) begin
            tick(1);
            if (wrap === 1'b1) wraps++;
        end
        if (rom_adr !== 4'hF) timeout("wrap_reach");
        chk("no_early_wrap", wraps, 0);
        tick(3);
        chk("wrap_pre", wrap, 1'b0);
        chk("wrap_pre_adr", rom_adr, 4'hF);
        tick(1);
        chk("wrap_pulse", wrap, 1'b1);
        chk("wrap_adr", rom_adr, 4'h0);
`ifdef SCROLL_ONESHOT_EN
        chk("wrap_busy", busy, 1'b0);
`else
        chk("wrap_busy", busy, 1'b1);
`endif
        tick(1);
        chk("wrap_end", wrap, 1'b0);
`ifdef SCROLL_ONESHOT_EN
        tick(8);
        chk("oneshot_adr", rom_adr, 4'h0);
        chk("oneshot_busy", busy, 1'b0);
`else
        tick(3);
        chk("loop_step", rom_adr, 4'h1);
`endif

        // Asynchronous reset between clock edges
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_seg", seg, 8'hFF);
        chk("arst_an", an, 4'hF);
        chk("arst_adr", rom_adr, 4'h0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_wrap", wrap, 1'b0);
        rst_n = 1'b1;
        tick(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
